// File: rtl/seg_pkg.sv
// Shared constants and state encoding for the binary-to-BCD display bridge.
package seg_pkg;

  // Controller states: waiting for a write, running double-dabble, driving the display bus.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    PUSH = 2'd2
  } state_t;

  // Largest value that fits in eight decimal digits.
  localparam logic [31:0] BCD_MAX_DEC = 32'd99_999_999;

  // Saturated display pattern shown for out-of-range inputs.
  localparam logic [31:0] BCD_SAT = 32'h9999_9999;

  // One double-dabble iteration per input bit.
  localparam int CONV_ITERS = 32;

  // Iteration counter value on the final iteration.
  localparam logic [4:0] CNT_LAST = 5'(CONV_ITERS - 1);

endpackage

// File: rtl/bcd_dd_step.sv
// One combinational double-dabble iteration: add-3 correction on each BCD
// digit, then a one-bit left shift of the 64-bit {bcd, bin} pair.
module bcd_dd_step (
  input  logic [31:0] i_bcd,
  input  logic [31:0] i_bin,
  output logic [31:0] o_bcd,
  output logic [31:0] o_bin
);

  logic [31:0] w_adj;
  logic [63:0] w_shift;

  // Eight independent add-3 cells; a 4-bit add keeps carries inside the digit.
  for (genvar gi = 0; gi < 8; gi++) begin : g_digit
    assign w_adj[gi*4 +: 4] = (i_bcd[gi*4 +: 4] >= 4'd5) ? (i_bcd[gi*4 +: 4] + 4'd3)
                                                         : i_bcd[gi*4 +: 4];
  end

  // Shift the corrected digits and the remaining binary bits as one register.
  assign w_shift = {w_adj, i_bin} << 1;
  assign {o_bcd, o_bin} = w_shift;

endmodule

// File: rtl/bin2bcd_bus.sv
// Bus slave that converts a written 32-bit binary value to eight BCD digits
// and forwards the result to the seven-segment display with one write cycle.
module bin2bcd_bus
  import seg_pkg::*;
(
  input  logic        sck,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        rw,
  input  logic [31:0] mosi,
  output logic [31:0] miso,
  output logic        seg_cs_n,
  output logic        seg_rw,
  output logic [31:0] seg_mosi,
  output logic        busy,
  output logic        ovf,
  output logic        drop
);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_bin;
  logic [31:0] r_bcd;
  logic [4:0]  r_cnt;
  logic [31:0] r_miso;
  logic        r_seg_cs_n;
  logic        r_seg_rw;
  logic [31:0] r_seg_mosi;
  logic        r_busy;
  logic        r_ovf;
  logic        r_drop;

  logic        w_wr;
  logic        w_too_big;
  logic        w_last;
  logic [31:0] w_step_bcd;
  logic [31:0] w_step_bin;

  assign w_wr      = ~cs_n & rw;
  assign w_too_big = (mosi > BCD_MAX_DEC);
  assign w_last    = (r_cnt == CNT_LAST);

  bcd_dd_step u_step (
    .i_bcd (r_bcd),
    .i_bin (r_bin),
    .o_bcd (w_step_bcd),
    .o_bin (w_step_bin)
  );

  // State register.
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: overflowing writes skip conversion and go straight to the push.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_wr) begin
          w_state_next = w_too_big ? PUSH : CONV;
        end
      end
      CONV: begin
        if (w_last) begin
          w_state_next = PUSH;
        end
      end
      PUSH: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath, status flags and the registered display bus; the display
  // strobe is asserted only on edges that enter PUSH, so it lasts one cycle.
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_miso     <= '0;
      r_seg_cs_n <= 1'b1;
      r_seg_rw   <= 1'b0;
      r_seg_mosi <= '0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_seg_cs_n <= 1'b1;
      r_seg_rw   <= 1'b0;
      r_seg_mosi <= '0;
      case (r_state)
        IDLE: begin
          if (w_wr) begin
            r_bin  <= mosi;
            r_cnt  <= '0;
            r_drop <= 1'b0;
            r_busy <= 1'b1;
            if (w_too_big) begin
              r_bcd      <= BCD_SAT;
              r_ovf      <= 1'b1;
              r_miso     <= BCD_SAT;
              r_seg_cs_n <= 1'b0;
              r_seg_rw   <= 1'b1;
              r_seg_mosi <= BCD_SAT;
            end else begin
              r_bcd <= '0;
              r_ovf <= 1'b0;
            end
          end
        end
        CONV: begin
          r_bcd <= w_step_bcd;
          r_bin <= w_step_bin;
          r_cnt <= r_cnt + 5'd1;
          if (w_wr) begin
            r_drop <= 1'b1;
          end
          if (w_last) begin
            r_miso     <= w_step_bcd;
            r_seg_cs_n <= 1'b0;
            r_seg_rw   <= 1'b1;
            r_seg_mosi <= w_step_bcd;
          end
        end
        PUSH: begin
          r_busy <= 1'b0;
          if (w_wr) begin
            r_drop <= 1'b1;
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign miso     = r_miso;
  assign seg_cs_n = r_seg_cs_n;
  assign seg_rw   = r_seg_rw;
  assign seg_mosi = r_seg_mosi;
  assign busy     = r_busy;
  assign ovf      = r_ovf;
  assign drop     = r_drop;

endmodule

// File: tb/tb_bin2bcd_bus.sv
// Self-checking bench for bin2bcd_bus: expected display writes are queued
// when a write is issued and matched against each observed display pulse.
module tb_bin2bcd_bus;

  logic        sck;
  logic        rst_n;
  logic        cs_n;
  logic        rw;
  logic [31:0] mosi;
  logic [31:0] miso;
  logic        seg_cs_n;
  logic        seg_rw;
  logic [31:0] seg_mosi;
  logic        busy;
  logic        ovf;
  logic        drop;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   n_pulse = 0;
  int   n_exp   = 0;
  int   cyc     = 0;

  bin2bcd_bus dut (
    .sck      (sck),
    .rst_n    (rst_n),
    .cs_n     (cs_n),
    .rw       (rw),
    .mosi     (mosi),
    .miso     (miso),
    .seg_cs_n (seg_cs_n),
    .seg_rw   (seg_rw),
    .seg_mosi (seg_mosi),
    .busy     (busy),
    .ovf      (ovf),
    .drop     (drop)
  );

  initial begin
    sck = 1'b0;
    forever #5 sck = ~sck;
  end

  always @(posedge sck) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference conversion by repeated division, independent of double-dabble.
  function automatic logic [31:0] ref_bcd(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] x;
    r = '0;
    x = v;
    if (v > 32'd99_999_999) return 32'h9999_9999;
    for (int d = 0; d < 8; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Called at a falling edge; the next rising edge (E0) sees the write.
  // Returns at the falling edge after E0.
  task automatic do_write(input logic [31:0] v, input bit accept);
    exp_t e;
    cs_n = 1'b0;
    rw   = 1'b1;
    mosi = v;
    if (accept) begin
      e.val = ref_bcd(v);
      e.cyc = cyc + 1 + ((v > 32'd99_999_999) ? 0 : 32);
      sb_q.push_back(e);
      n_exp++;
    end
    $display("write val=%h accept=%0d cyc=%0d", v, accept, cyc + 1);
    @(negedge sck);
    cs_n = 1'b1;
    rw   = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 64) begin
      @(negedge sck);
      k++;
    end
    chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  // Display-side monitor: every strobe must match the oldest queued expectation.
  always @(negedge sck) begin
    if (rst_n && seg_cs_n == 1'b0) begin
      exp_t e;
      n_pulse++;
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", seg_mosi, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        $display("push val=%h exp=%h cyc=%0d exp_cyc=%0d", seg_mosi, e.val, cyc, e.cyc);
        chk("seg_mosi", seg_mosi, e.val);
        chk("seg_rw", {31'b0, seg_rw}, 32'd1);
        chk("pulse_cyc", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    cs_n  = 1'b1;
    rw    = 1'b0;
    mosi  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge sck);
    chk("rst_miso", miso, 32'd0);
    chk("rst_seg_cs_n", {31'b0, seg_cs_n}, 32'd1);
    chk("rst_seg_rw", {31'b0, seg_rw}, 32'd0);
    chk("rst_seg_mosi", seg_mosi, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_drop", {31'b0, drop}, 32'd0);
    rst_n = 1'b1;
    @(negedge sck);

    // Read while idle has no side effects.
    cs_n = 1'b0; rw = 1'b0; mosi = 32'd123;
    @(negedge sck);
    cs_n = 1'b1;
    chk("rd_idle_busy", {31'b0, busy}, 32'd0);
    chk("rd_idle_miso", miso, 32'd0);

    // Zero: strobe only between E32 and E33.
    do_write(32'd0, 1'b1);
    chk("z_busy_e0", {31'b0, busy}, 32'd1);
    repeat (31) @(negedge sck);
    chk("z_cs_e31", {31'b0, seg_cs_n}, 32'd1);
    @(negedge sck);
    chk("z_cs_e32", {31'b0, seg_cs_n}, 32'd0);
    @(negedge sck);
    chk("z_busy_e33", {31'b0, busy}, 32'd0);
    chk("z_cs_e33", {31'b0, seg_cs_n}, 32'd1);
    chk("z_miso", miso, 32'd0);
    chk("z_ovf", {31'b0, ovf}, 32'd0);

    // 12,345,678 with a read during conversion; next write lands on E34.
    do_write(32'h00BC614E, 1'b1);
    cs_n = 1'b0; rw = 1'b0;
    @(negedge sck);
    cs_n = 1'b1;
    chk("rd_conv_drop", {31'b0, drop}, 32'd0);
    chk("rd_conv_busy", {31'b0, busy}, 32'd1);
    repeat (31) @(negedge sck);
    chk("n_busy_e32", {31'b0, busy}, 32'd1);
    chk("n_miso_e32", miso, 32'h12345678);
    @(negedge sck);
    chk("n_busy_e33", {31'b0, busy}, 32'd0);

    // Largest in-range value, then the first overflowing one.
    do_write(32'd99_999_999, 1'b1);
    wait_idle();
    chk("max_ovf", {31'b0, ovf}, 32'd0);
    chk("max_miso", miso, 32'h99999999);
    do_write(32'd100_000_000, 1'b1);
    chk("ov_ovf", {31'b0, ovf}, 32'd1);
    chk("ov_busy_e0", {31'b0, busy}, 32'd1);
    chk("ov_cs_e0", {31'b0, seg_cs_n}, 32'd0);
    chk("ov_miso", miso, 32'h99999999);
    @(negedge sck);
    chk("ov_busy_e1", {31'b0, busy}, 32'd0);
    chk("ov_cs_e1", {31'b0, seg_cs_n}, 32'd1);

    // Write while converting is dropped; a later write clears drop.
    do_write(32'h0000FFFF, 1'b1);
    repeat (9) @(negedge sck);
    do_write(32'd42, 1'b0);
    chk("drop_set", {31'b0, drop}, 32'd1);
    wait_idle();
    chk("drop_sticky", {31'b0, drop}, 32'd1);
    chk("drop_miso", miso, 32'h00065535);
    do_write(32'd42, 1'b1);
    chk("drop_clr", {31'b0, drop}, 32'd0);
    wait_idle();
    chk("w42_miso", miso, 32'h00000042);

    // Write on the PUSH->IDLE edge (E33) is dropped.
    do_write(32'd5, 1'b1);
    repeat (32) @(negedge sck);
    do_write(32'd9, 1'b0);
    chk("edge_drop", {31'b0, drop}, 32'd1);
    chk("edge_busy", {31'b0, busy}, 32'd0);
    chk("edge_miso", miso, 32'h00000005);

    // Reset between E15 and E16 aborts the conversion.
    do_write(32'd7, 1'b1);
    repeat (15) @(negedge sck);
    #2 rst_n = 1'b0;
    #1;
    chk("rc_busy", {31'b0, busy}, 32'd0);
    chk("rc_miso", miso, 32'd0);
    chk("rc_cs", {31'b0, seg_cs_n}, 32'd1);
    chk("rc_drop", {31'b0, drop}, 32'd0);
    chk("rc_seg_mosi", seg_mosi, 32'd0);
    sb_q.delete();
    n_exp--;
    @(negedge sck);
    rst_n = 1'b1;
    @(negedge sck);
    do_write(32'd7, 1'b1);
    wait_idle();
    chk("r7_miso", miso, 32'h00000007);

    // Reset during PUSH releases the display strobe immediately.
    do_write(32'hFFFF_FFFF, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rp_cs", {31'b0, seg_cs_n}, 32'd1);
    chk("rp_ovf", {31'b0, ovf}, 32'd0);
    @(negedge sck);
    rst_n = 1'b1;
    repeat (2) @(negedge sck);

    chk("pulse_count", n_pulse, n_exp);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
